// File: rtl/cic_nr16.sv
// cic_nr16 -- 1-bit PDM to PCM CIC decimator, R = 16, M = 1, N stages.
//
// First stage of the audio decimation chain. N integrators run at the PDM bit
// rate; an internal 4-bit counter selects one clk in 16 on which the comb
// chain is evaluated and a new unsigned sample is presented with a one-clk
// valid strobe. Gain is 16^N, so the output range is 0..16^N inclusive.
//
// Ports:
//   clk      PDM bit clock, all state on its rising edge
//   rst      asynchronous reset, active low
//   x_in     PDM bit (0 weighs 0, 1 weighs +1)
//   x_ce     input clock enable (only when CIC_INPUT_CE_EN is defined)
//   y_out    decimated unsigned sample, OW = 4*N+1 bits
//   y_valid  one-clk pulse when y_out updates
//
// Optional feature macro: CIC_INPUT_CE_EN adds x_ce. When x_ce is low the
// integrators and the decimation counter hold. Without the macro the block
// behaves as if x_ce were tied high.

module cic_nr16 #(
    parameter  int N  = 4,
    localparam int OW = 4 * N + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_in,
`ifdef CIC_INPUT_CE_EN
    input  logic          x_ce,
`endif
    output logic [OW-1:0] y_out,
    output logic          y_valid
);

    logic          ce;
    logic          tick;
    logic [3:0]    cnt_reg;
    logic [3:0]    cnt_next;

    // integ_reg[0] is the first integrator, integ_reg[N-1] the last.
    logic [OW-1:0] integ_reg [N];
    // Value each integrator adds on an enabled clk.
    logic [OW-1:0] stage_in  [N];
    // comb_c[0] is the comb input, comb_c[N] the filter output.
    logic [OW-1:0] comb_c    [N+1];
    // dly_reg[k] holds comb_c[k] from the previous tick.
    logic [OW-1:0] dly_reg   [N];

`ifdef CIC_INPUT_CE_EN
    assign ce = x_ce;
`else
    assign ce = 1'b1;
`endif

    assign cnt_next = cnt_reg + 4'd1;
    assign tick     = (cnt_reg == 4'd15) && ce;

    // Each integrator adds the registered output of the one before it, so
    // every stage is a full pipeline register. Wrap-around is harmless: the
    // comb differences recover the exact result modulo 2^OW, and the true
    // result never exceeds 16^N < 2^OW.
    assign stage_in[0] = {{(OW-1){1'b0}}, x_in};
    assign comb_c[0]   = integ_reg[N-1];

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_stage_in
            assign stage_in[gi] = integ_reg[gi-1];
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_comb
            assign comb_c[gi+1] = comb_c[gi] - dly_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            for (int i = 0; i < N; i++) begin
                integ_reg[i] <= '0;
                dly_reg[i]   <= '0;
            end
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= tick;
            if (ce) begin
                cnt_reg <= cnt_next;
                for (int i = 0; i < N; i++) begin
                    integ_reg[i] <= integ_reg[i] + stage_in[i];
                end
            end
            if (tick) begin
                for (int i = 0; i < N; i++) begin
                    dly_reg[i] <= comb_c[i];
                end
                y_out <= comb_c[N];
            end
        end
    end

endmodule

// File: tb/tb_cic_nr16.sv
// tb_cic_nr16 -- self-checking bench for cic_nr16 (N = 4).
//
// The reference is a convolution: the impulse response is the 16-tap box
// filter convolved with itself N times, shifted by the integrator pipeline
// depth. A compare process checks y_valid and y_out every clk against it;
// directed scenarios add literal expectations that also pin the model.

module tb_cic_nr16;

    localparam int N  = 4;
    localparam int OW = 4 * N + 1;
    localparam int HL = N * 15 + 1;
    localparam int HM = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x_in = 1'b0;
    logic          x_ce = 1'b1;
    logic [OW-1:0] y_out;
    logic          y_valid;

    always #5 clk = ~clk;

    cic_nr16 #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x_in),
`ifdef CIC_INPUT_CE_EN
        .x_ce    (x_ce),
`endif
        .y_out   (y_out),
        .y_valid (y_valid)
    );

    int checks   = 0;
    int failures = 0;

    int h [HL];
    bit hist [HM];
    int e     = 0;
    int cyc   = 0;
    int rel   = 0;
    int exp_y = 0;
    bit exp_v = 1'b0;
    int sv_q [$];
    int st_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Output after the j-th strobe: input bit of enabled edge s reaches the
    // tick on edge 16j through impulse tap 16j - N - s.
    function automatic int model_y(input int j);
        int acc;
        int s;
        acc = 0;
        for (int m = 0; m < HL; m++) begin
            s = 16 * j - N - m;
            if (s >= 1 && s < HM) acc += h[m] * int'(hist[s]);
        end
        return acc & ((1 << OW) - 1);
    endfunction

    // Model: count enabled edges since reset release and record the bits.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            e     = 0;
            exp_y = 0;
            exp_v = 1'b0;
        end else if (x_ce) begin
            e++;
            if (e < HM) hist[e] = x_in;
            if (e % 16 == 0) begin
                exp_y = model_y(e / 16);
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end else begin
            exp_v = 1'b0;
        end
    end

    always @(negedge rst) begin
        e     = 0;
        exp_y = 0;
        exp_v = 1'b0;
    end

    // Compare process, one line per strobe.
    always @(posedge clk) begin
        #1;
        chk("y_valid", 32'(y_valid), 32'(exp_v));
        chk("y_out", 32'(y_out), 32'(exp_y));
        if (y_valid === 1'b1) begin
            sv_q.push_back(int'(y_out));
            st_q.push_back(cyc - rel);
            $display("strobe t=%0d y_out=%0d model=%0d", cyc - rel, y_out, exp_y);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        x_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rel = cyc;
        sv_q.delete();
        st_q.delete();
    endtask

    initial begin
        int tmp [HL];
        int acc;
        int nz;

        // Impulse response: box(16) convolved N times.
        for (int m = 0; m < HL; m++) h[m] = (m < 16) ? 1 : 0;
        for (int k = 1; k < N; k++) begin
            tmp = h;
            for (int m = 0; m < HL; m++) begin
                acc = 0;
                for (int t = 0; t < 16; t++) if (m - t >= 0) acc += tmp[m - t];
                h[m] = acc;
            end
        end
        acc = 0;
        foreach (h[m]) acc += h[m];
        chk("model_gain", acc, 65536);
        chk("model_h6", h[6], 84);

        #2 rst = 1'b0;
        #1 chk("reset_y_out", 32'(y_out), 0);
        chk("reset_y_valid", 32'(y_valid), 0);

        // All zeros for 512 clks.
        do_reset();
        for (int i = 0; i < 512; i++) begin
            x_in = 1'b0;
            @(negedge clk);
        end
        chk("zeros_count", sv_q.size(), 32);
        if (st_q.size() > 0) chk("zeros_first_t", st_q[0], 16);
        for (int i = 1; i < st_q.size(); i++) chk("zeros_spacing", st_q[i] - st_q[i-1], 16);
        foreach (sv_q[i]) chk("zeros_value", sv_q[i], 0);

        // All ones.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            x_in = 1'b1;
            @(negedge clk);
        end
        chk("ones_count", sv_q.size(), 8);
        if (sv_q.size() == 8) begin
            chk("ones_first", sv_q[0], 1365);
            for (int i = 0; i < 4; i++) chk("ones_rise", 32'(sv_q[i] < sv_q[i+1]), 1);
            for (int i = 4; i < 8; i++) chk("ones_steady", sv_q[i], 65536);
        end

        // Alternating 1,0.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            x_in = (i % 2 == 0);
            @(negedge clk);
        end
        chk("alt_count", sv_q.size(), 8);
        if (sv_q.size() == 8)
            for (int i = 4; i < 8; i++) chk("alt_steady", sv_q[i], 32768);

        // Single one then zeros.
        do_reset();
        for (int i = 0; i < 160; i++) begin
            x_in = (i == 5);
            @(negedge clk);
        end
        acc = 0;
        nz  = 0;
        foreach (sv_q[i]) begin
            acc += sv_q[i];
            if (sv_q[i] != 0) nz++;
        end
        chk("imp_sum", acc, 4096);
        chk("imp_nz_le5", 32'(nz <= 5), 1);
        if (sv_q.size() > 0) chk("imp_first", sv_q[0], 84);
        for (int i = 5; i < sv_q.size(); i++) chk("imp_tail", sv_q[i], 0);

        // Mid-frame reset during all-ones.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            x_in = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        #1 chk("midrst_y_out", 32'(y_out), 0);
        chk("midrst_y_valid", 32'(y_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rel = cyc;
        sv_q.delete();
        st_q.delete();
        for (int i = 0; i < 128; i++) begin
            x_in = 1'b1;
            @(negedge clk);
        end
        chk("midrst_count", sv_q.size(), 8);
        if (sv_q.size() == 8) begin
            chk("midrst_first_t", st_q[0], 16);
            chk("midrst_first", sv_q[0], 1365);
            for (int i = 4; i < 8; i++) chk("midrst_steady", sv_q[i], 65536);
        end

`ifdef CIC_INPUT_CE_EN
        // Enable on one clk in four, all ones.
        do_reset();
        for (int i = 0; i < 512; i++) begin
            x_in = 1'b1;
            x_ce = (i % 4 == 0);
            @(negedge clk);
        end
        x_ce = 1'b1;
        chk("ce_count", sv_q.size(), 8);
        for (int i = 1; i < st_q.size(); i++) chk("ce_spacing", st_q[i] - st_q[i-1], 64);
        if (sv_q.size() == 8)
            for (int i = 5; i < 8; i++) chk("ce_steady", sv_q[i], 65536);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cic_nr16.md
Name: cic_nr16

Overview:
- 1-bit PDM-to-PCM CIC decimator: N integrator stages, decimation R = 16, differential delay M = 1.
- First stage of the audio decimation chain.
- Feeds the halfband/FIR stages with a 17-bit (N=4) unsigned sample once every 16 clocks, qualified by a one-cycle valid strobe.
- Single clock domain; the decimation counter is internal, so no derived clock is needed.

Parameters:
- N, default 4, number of integrator and comb stages; legal range 1..6.
- OW (localparam), 4*N+1, internal and output width in bits; N=4 gives 17.

Ports:
- clk  input  1  PDM bit clock; all state on its rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- x_in  input  1  PDM bit; 0 weighs 0, 1 weighs +1 (unsigned).
- y_out  output  OW  decimated unsigned sample; range 0..16^N (N=4: 0..65536).
- y_valid  output  1  one-clk pulse when y_out updates.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-to-clk deassert handled by the reset tree):
  - All integrators, comb delay registers and the decimation counter go to 0.
  - y_out = 0; y_valid = 0.
  - Reset mid-operation discards all history; the next valid strobe comes 16 clks after release, like the first one after power-up.
- Integrators, every clk:
  - I1 <= I1 + x_in (zero-extended).
  - Ik <= Ik + I(k-1) for k = 2..N; each stage is registered.
  - All adders are OW bits wide with modulo 2^OW wrap, no saturation; the CIC wrap property guarantees a correct final result.
- Decimation counter:
  - 4 bits, counts 0..15, increments every clk, wraps 15 -> 0.
  - The tick is the cycle where counter == 15.
- Comb chain, evaluated only on the tick:
  - C0 = IN; Ck = C(k-1) - D(k-1), where D(k-1) is the value C(k-1) held at the previous tick.
  - Subtraction is modulo 2^OW.
  - On the tick edge: every Dk is updated, y_out <= CN, and y_valid <= 1 for the following cycle.
- y_valid:
  - High exactly 1 clk in every 16; the first pulse comes 16 clks after reset release.
  - y_out holds its value between pulses.
- Gain is 16^N.
  - Steady-state all-ones input gives y_out = 16^N, which is 0x10000 for N=4 and still fits OW bits.
  - All-zeros input gives 0.
- Latency: from an x_in bit to its first influence on y_out is at most N + 16 clks. The impulse response spans N*15 + 1 input samples.

Optional Feature:
- Macro: CIC_INPUT_CE_EN.
- Defined:
  - Adds input port x_ce (1 bit).
  - The integrators and the decimation counter advance only on clks where x_ce = 1; otherwise all state holds.
  - The tick is counter == 15 AND x_ce = 1.
  - y_valid still lasts one clk.
  - Reset behaviour is unchanged.
- Undefined: no x_ce port; behaviour is identical to x_ce tied to 1.

Test Plan:
- Hold x_in = 0 for 512 clks after reset -> every y_valid pulse carries y_out = 0; pulses are exactly 16 clks apart, the first 16 clks after release.
- Hold x_in = 1 continuously (N=4) -> from the 5th y_valid onward y_out = 65536 (0x10000); earlier outputs rise monotonically.
- Alternating 1,0,1,0 bitstream (N=4) -> from the 5th strobe onward y_out = 32768.
- Single 1 followed by zeros (N=4) -> nonzero outputs on at most 5 consecutive strobes; they sum to 4096 (R^(N-1)); all later outputs are 0.
- Drive all-ones for 100 clks, pull rst low for 3 clks mid-frame, then continue all-ones:
  - y_out and y_valid are 0 immediately on assertion.
  - The first post-reset strobe comes 16 clks after release.
  - The response then matches the fresh all-ones scenario.
- With CIC_INPUT_CE_EN, x_ce = 1 on one clk in four and all-ones input -> strobes every 64 clks; steady-state y_out = 65536.
